// File: rtl/date_sequencer.sv
// date_sequencer: holds a calendar date, advances or loads it, and captures the
// external day-of-year calculator result after a configurable settle time.
module date_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [5:0]  loadDay,
   input  logic [3:0]  loadMonth,
   input  logic [10:0] loadYear,
   input  logic        step,
   output logic [5:0]  dayOfMonth,
   output logic [3:0]  month,
   output logic [10:0] year,
   input  logic [8:0]  calcDayOfYear,
   output logic [8:0]  dayOfYear,
   output logic        valid,
   output logic        busy,
   output logic        error
);
   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  day_q, day_d;
   logic [3:0]  mon_q, mon_d;
   logic [10:0] yr_q, yr_d;
   logic [8:0]  doy_q, doy_d;
   logic        valid_q, valid_d, err_q, err_d;
   logic        load_ok, last_day;

   // Unknown months yield length 0, so any day fails the range check.
   function automatic logic [5:0] mlen(input logic [3:0] m, input logic [10:0] y);
      logic leap;
      leap = (y[1:0] == 2'd0) && (((y % 11'd100) != 11'd0) || ((y % 11'd400) == 11'd0));
      case (m)
         4'd2:                         mlen = leap ? 6'd29 : 6'd28;
         4'd4, 4'd6, 4'd9, 4'd11:      mlen = 6'd30;
         4'd1, 4'd3, 4'd5, 4'd7, 4'd8,
         4'd10, 4'd12:                 mlen = 6'd31;
         default:                      mlen = 6'd0;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         day_q   <= 6'd1;
         mon_q   <= 4'd1;
         yr_q    <= 11'd0;
         doy_q   <= 9'd1;
         valid_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         day_q   <= day_d;
         mon_q   <= mon_d;
         yr_q    <= yr_d;
         doy_q   <= doy_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      load_ok  = (loadDay != 6'd0) && (loadDay <= mlen(loadMonth, loadYear));
      last_day = day_q >= mlen(mon_q, yr_q);
      state_d  = state_q;
      cnt_d    = cnt_q;
      day_d    = day_q;
      mon_d    = mon_q;
      yr_d     = yr_q;
      doy_d    = doy_q;
      valid_d  = valid_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               err_d = !load_ok;
               if (load_ok) begin
                  day_d   = loadDay;
                  mon_d   = loadMonth;
                  yr_d    = loadYear;
                  valid_d = 1'b0;
                  state_d = SETTLE;
                  cnt_d   = 4'(SETTLE_CYCLES);
               end
            end else if (step) begin
               day_d   = last_day ? 6'd1 : day_q + 6'd1;
               mon_d   = !last_day ? mon_q : (mon_q == 4'd12 ? 4'd1 : mon_q + 4'd1);
               yr_d    = (last_day && mon_q == 4'd12) ? yr_q + 11'd1 : yr_q;
               valid_d = 1'b0;
               err_d   = 1'b0;
               state_d = SETTLE;
               cnt_d   = 4'(SETTLE_CYCLES);
            end
         end
         SETTLE: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q <= 4'd1) ? CAPTURE : SETTLE;
         end
         CAPTURE: begin
            doy_d   = calcDayOfYear;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy       = state_q != IDLE;
      dayOfMonth = day_q;
      month      = mon_q;
      year       = yr_q;
      dayOfYear  = doy_q;
      valid      = valid_q;
      error      = err_q;
   end
endmodule

// File: tb/tb_date_sequencer.sv
// tb_date_sequencer: directed stimulus with a calendar-level reference model
// compared every cycle, plus literal expectations for the key dates.
module tb_date_sequencer;
   localparam int S = 2;

   bit          clk;
   logic        reset = 1'b1;
   logic        load = 1'b0, step = 1'b0;
   logic [5:0]  loadDay = 6'd1;
   logic [3:0]  loadMonth = 4'd1;
   logic [10:0] loadYear = 11'd0;
   logic [5:0]  dayOfMonth;
   logic [3:0]  month;
   logic [10:0] year;
   logic [8:0]  calcDayOfYear, dayOfYear;
   logic        valid, busy, error;

   int total = 0, bad = 0;
   bit run_cmp = 1'b0;

   int m_day = 1, m_mon = 1, m_yr = 0, m_doy = 1, m_left = 0;
   bit m_valid = 1'b1, m_err = 1'b0;

   date_sequencer #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .load(load), .loadDay(loadDay), .loadMonth(loadMonth),
      .loadYear(loadYear), .step(step), .dayOfMonth(dayOfMonth), .month(month), .year(year),
      .calcDayOfYear(calcDayOfYear), .dayOfYear(dayOfYear), .valid(valid), .busy(busy),
      .error(error)
   );

   always #5 clk = ~clk;

   function automatic bit is_leap(int y);
      return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
   endfunction

   function automatic int mdays(int m, int y);
      int t[12];
      t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      if (m < 1 || m > 12) return 31;
      return (m == 2 && is_leap(y)) ? 29 : t[m-1];
   endfunction

   function automatic int doy_of(int d, int m, int y);
      int s;
      s = d;
      for (int i = 1; i < m && i <= 12; i++) s += mdays(i, y);
      return s;
   endfunction

   function automatic bit legal(int d, int m, int y);
      return m >= 1 && m <= 12 && d >= 1 && d <= mdays(m, y);
   endfunction

   // Tomorrow via ordinal day number, rolling into the next year when past its end.
   function automatic void next_date(input int d0, input int m0, input int y0,
                                     output int d, output int m, output int y);
      int n;
      n = doy_of(d0, m0, y0) + 1;
      y = y0;
      m = 1;
      if (n > (is_leap(y0) ? 366 : 365)) begin
         d = 1;
         y = (y0 + 1) % 2048;
      end else begin
         while (n > mdays(m, y)) begin
            n -= mdays(m, y);
            m++;
         end
         d = n;
      end
   endfunction

   assign calcDayOfYear = 9'(doy_of(int'(dayOfMonth), int'(month), int'(year)));

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_day = 1; m_mon = 1; m_yr = 0; m_doy = 1; m_left = 0;
         m_valid = 1'b1; m_err = 1'b0;
      end else if (m_left != 0) begin
         m_left--;
         if (m_left == 0) begin
            m_valid = 1'b1;
            m_doy = doy_of(m_day, m_mon, m_yr);
         end
      end else if (load) begin
         if (legal(int'(loadDay), int'(loadMonth), int'(loadYear))) begin
            m_day = int'(loadDay); m_mon = int'(loadMonth); m_yr = int'(loadYear);
            m_valid = 1'b0; m_err = 1'b0; m_left = S + 1;
         end else m_err = 1'b1;
      end else if (step) begin
         next_date(m_day, m_mon, m_yr, m_day, m_mon, m_yr);
         m_valid = 1'b0; m_err = 1'b0; m_left = S + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("cmp_day", int'(dayOfMonth), m_day);
         chk("cmp_month", int'(month), m_mon);
         chk("cmp_year", int'(year), m_yr);
         chk("cmp_doy", int'(dayOfYear), m_doy);
         chk("cmp_valid", int'(valid), int'(m_valid));
         chk("cmp_busy", int'(busy), int'(m_left != 0));
         chk("cmp_error", int'(error), int'(m_err));
      end
   end

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 30) begin
         @(negedge clk);
         k++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   task automatic ld(input int d, input int m, input int y);
      loadDay = 6'(d); loadMonth = 4'(m); loadYear = 11'(y);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_idle();
   endtask

   task automatic st();
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      wait_idle();
   endtask

   task automatic chk_date(input string name, input int d, input int m, input int y, input int doy);
      chk({name, "_day"}, int'(dayOfMonth), d);
      chk({name, "_month"}, int'(month), m);
      chk({name, "_year"}, int'(year), y);
      chk({name, "_doy"}, int'(dayOfYear), doy);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      run_cmp = 1'b1;
      @(negedge clk);
      chk_date("reset", 1, 1, 0, 1);
      chk("reset_valid", int'(valid), 1);
      chk("reset_busy", int'(busy), 0);
      reset = 1'b0;
      // first step right after release, latency pinned cycle by cycle
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      chk("lat_busy0", int'(busy), 1);
      chk("lat_valid0", int'(valid), 0);
      chk("lat_day", int'(dayOfMonth), 2);
      repeat (S) begin
         @(negedge clk);
         chk("lat_busy_mid", int'(busy), 1);
      end
      @(negedge clk);
      chk("lat_busy_end", int'(busy), 0);
      chk("lat_valid_end", int'(valid), 1);
      chk_date("first_step", 2, 1, 0, 2);

      ld(28, 2, 1900);
      chk("ld1900_doy", int'(dayOfYear), 59);
      st();
      chk_date("step1900", 1, 3, 1900, 60);

      ld(28, 2, 2000);
      st();
      chk_date("step2000a", 29, 2, 2000, 60);
      st();
      chk_date("step2000b", 1, 3, 2000, 61);

      ld(31, 12, 2047);
      chk("ld2047_doy", int'(dayOfYear), 365);
      st();
      chk_date("wrap", 1, 1, 0, 1);

      ld(29, 2, 2001);
      chk("bad_ld_err", int'(error), 1);
      chk("bad_ld_busy", int'(busy), 0);
      chk("bad_ld_valid", int'(valid), 1);
      chk_date("bad_ld", 1, 1, 0, 1);
      ld(1, 3, 2001);
      chk("good_ld_err", int'(error), 0);
      chk("good_ld_doy", int'(dayOfYear), 60);
      ld(0, 5, 2001);
      chk("day0_err", int'(error), 1);
      ld(1, 13, 2001);
      chk("mon13_err", int'(error), 1);
      st();
      chk("step_clr_err", int'(error), 0);
      chk_date("after_err_step", 2, 3, 2001, 61);

      loadDay = 6'd15; loadMonth = 4'd6; loadYear = 11'd2010;
      load = 1'b1; step = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("ldstep_day", int'(dayOfMonth), 15);
      @(negedge clk);
      step = 1'b0;
      wait_idle();
      chk_date("ldstep", 15, 6, 2010, 166);
      repeat (2) @(negedge clk);
      chk("ldstep_hold_day", int'(dayOfMonth), 15);

      step = 1'b1;
      @(negedge clk);
      @(negedge clk);
      step = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      chk_date("step_busy_ign", 16, 6, 2010, 167);

      // asynchronous reset mid-calculation
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk_date("async_rst", 1, 1, 0, 1);
      chk("async_rst_valid", int'(valid), 1);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_err", int'(error), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (S + 3) @(negedge clk);
      chk_date("no_capture", 1, 1, 0, 1);
      chk("no_capture_busy", int'(busy), 0);

      run_cmp = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/date_sequencer.md
DATE_SEQUENCER -- requirements
Module: date_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, SHALL set the number of cycles the date is held on the calculator inputs before dayOfYear is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; SHALL force the reset state immediately, independent of clk.
REQ-004 load  input  1  request to load loadDay/loadMonth/loadYear as the current date.
REQ-005 loadDay  input  6  day-of-month to load; legal range 1..31.
REQ-006 loadMonth  input  4  month to load; legal range 1..12.
REQ-007 loadYear  input  11  year to load; range 0..2047.
REQ-008 step  input  1  request to advance the current date by one day.
REQ-009 dayOfMonth  output  6  current day-of-month, registered; drives the external day-of-year calculator.
REQ-010 month  output  4  current month, registered; drives the calculator.
REQ-011 year  output  11  current year, registered; drives the calculator.
REQ-012 calcDayOfYear  input  9  combinational result from the calculator for the current date.
REQ-013 dayOfYear  output  9  registered day-of-year of the current date, range 1..366.
REQ-014 valid  output  1  high when dayOfYear corresponds to the current date.
REQ-015 busy  output  1  high while a calculation is in flight; load and step are ignored.
REQ-016 error  output  1  high after a rejected load.

Function
REQ-017 The FSM SHALL have three states: IDLE, SETTLE and CAPTURE; busy = (state != IDLE).
REQ-018 In IDLE, when load=1, the block SHALL validate the load fields:
  - day >= 1; month in 1..12; day <= month length for loadYear.
  - Month lengths: 31,28/29,31,30,31,30,31,31,30,31,30,31.
REQ-019 Leap year SHALL be (year%4==0) and (year%100!=0 or year%400==0), so year 0 and 2000 are leap and 1900 is not.
REQ-020 A valid load SHALL, at the same edge:
  - copy the load fields to dayOfMonth/month/year;
  - clear valid and error;
  - enter SETTLE.
REQ-021 An invalid load SHALL set error=1 and leave the date, dayOfYear, valid and the state unchanged.
REQ-022 In IDLE, when step=1 and load=0, the block SHALL advance the date, clear valid and error, and enter SETTLE, all at the same edge.
REQ-023 Advance rules:
  - day < month length: day+1.
  - Otherwise day=1; if month < 12, month+1.
  - Otherwise month=1 and year+1; year 2047 wraps to 0.
REQ-024 When load and step are both 1 in IDLE, load SHALL win and the step SHALL be dropped.
REQ-025 load and step SHALL be ignored (not queued) while busy=1.
REQ-026 The block SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, counted by a 4-bit down-counter, then go to CAPTURE.
REQ-027 At the CAPTURE edge the block SHALL do all of the following:
  - register calcDayOfYear into dayOfYear;
  - set valid=1;
  - return to IDLE.
REQ-028 Latency: for a request accepted at edge E0, valid SHALL rise and busy SHALL fall at edge E0+SETTLE_CYCLES+1.
REQ-029 dayOfMonth/month/year SHALL be stable from acceptance through CAPTURE.
REQ-030 dayOfYear SHALL be unchanged except at CAPTURE and reset.

Reset
REQ-031 While reset=1 the block SHALL hold these values:
  - state=IDLE, SETTLE counter=0;
  - dayOfMonth=1, month=1, year=0;
  - dayOfYear=1, valid=1, busy=0, error=0.
REQ-032 Reset asserted in SETTLE or CAPTURE SHALL abort the calculation, discard any result, and apply the values of REQ-031 immediately.
REQ-033 The first accepted request SHALL be possible at the first rising edge after reset deasserts.

Verification
REQ-034 Reset release, then step pulse -> busy=1 next edge, date 0000-01-02; SETTLE_CYCLES+1 edges after acceptance valid=1, dayOfYear=2, busy=0.
REQ-035 Leap-year stepping:
  - load 1900-02-28, wait, step -> 1900-03-01, dayOfYear=60.
  - load 2000-02-28, step -> 2000-02-29, dayOfYear=60; step again -> 2000-03-01, dayOfYear=61.
REQ-036 Load 2047-12-31 (dayOfYear=365), step -> 0000-01-01, dayOfYear=1.
REQ-037 Load 2001-02-29 -> error=1, busy stays 0, date/dayOfYear/valid unchanged; a following load of 2001-03-01 -> error=0, dayOfYear=60.
REQ-038 Load+step in the same cycle -> only the load is applied; a step pulse during SETTLE -> ignored, date unchanged after CAPTURE.
REQ-039 Reset pulse in SETTLE, asynchronous to clk -> all outputs return to REQ-031 values immediately; no later CAPTURE occurs.
